// File: rtl/spi_sample_receiver_if.sv
// SPI pin bundle plus the committed-sample outputs of spi_sample_receiver.
// The master side drives the SPI pins and the receiver drives the sample fields.
interface spi_sample_receiver_if #(
    parameter int unsigned FREQ_WIDTH = 14,
    parameter int unsigned AMP_WIDTH  = 8
);
    logic                  input_SPI_SCLK;
    logic                  input_SPI_CS_n;
    logic                  input_SPI_SDO;
    logic [FREQ_WIDTH-1:0] outputFrequencySample;
    logic [AMP_WIDTH-1:0]  outputAmplitudeSample;
    logic                  outputSampleValid;
    logic                  outputFrameError;
    logic [15:0]           outputFrameCount;
    logic                  inputLight;

    modport master (
        output input_SPI_SCLK, input_SPI_CS_n, input_SPI_SDO,
        input  outputFrequencySample, outputAmplitudeSample, outputSampleValid,
        input  outputFrameError, outputFrameCount, inputLight
    );

    modport slave (
        input  input_SPI_SCLK, input_SPI_CS_n, input_SPI_SDO,
        output outputFrequencySample, outputAmplitudeSample, outputSampleValid,
        output outputFrameError, outputFrameCount, inputLight
    );
endinterface

// File: rtl/spi_sample_receiver.sv
// Synchronous SPI slave receiving one MSB-first frame per CS_n low period and
// committing its frequency/amplitude fields atomically, rejecting malformed frames.
module spi_sample_receiver #(
    parameter int unsigned FREQ_WIDTH  = 14,
    parameter int unsigned AMP_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SAMPLE_EDGE = 0
) (
    input  logic                  CLK_50Mhz,
    input  logic                  reset_n,
    spi_sample_receiver_if.slave  spi
);

    localparam int unsigned W     = FREQ_WIDTH + AMP_WIDTH;
    localparam int unsigned CNT_W = $clog2(W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdo_sync_q;
    logic                   cs_hist_q, sclk_hist_q;
    logic [SYNC_STAGES:0]   prime_q;

    logic cs_now_c, sclk_now_c, sdo_now_c, primed_c;
    logic cs_fall_c, cs_rise_c, sclk_edge_c;
    logic cs_fall_q, cs_rise_q, sclk_edge_q, sdo_q;

    state_t                state_q, state_d;
    logic [W-1:0]          shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [AMP_WIDTH-1:0]  amp_q, amp_d;
    logic [15:0]           count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  light_q, light_d;

    // Pin synchronisers, history flops and a startup mask so that CS_n already
    // low at reset release is never mistaken for a falling edge.
    always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            sdo_sync_q  <= '0;
            cs_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b0;
            prime_q     <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.input_SPI_CS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.input_SPI_SCLK};
            sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], spi.input_SPI_SDO};
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        cs_now_c    = cs_sync_q[SYNC_STAGES-1];
        sclk_now_c  = sclk_sync_q[SYNC_STAGES-1];
        sdo_now_c   = sdo_sync_q[SYNC_STAGES-1];
        primed_c    = prime_q[SYNC_STAGES];
        cs_fall_c   = primed_c & cs_hist_q & ~cs_now_c;
        cs_rise_c   = primed_c & ~cs_hist_q & cs_now_c;
        sclk_edge_c = primed_c & ((SAMPLE_EDGE == 0) ? (~sclk_hist_q & sclk_now_c)
                                                     : (sclk_hist_q & ~sclk_now_c));
    end

    // Registered edge events; SDO is registered alongside so it stays aligned.
    always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_edge_q <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            cs_fall_q   <= cs_fall_c;
            cs_rise_q   <= cs_rise_c;
            sclk_edge_q <= sclk_edge_c;
            sdo_q       <= sdo_now_c;
        end
    end

    always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            amp_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            light_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            count_q <= count_d;
            valid_q <= valid_d;
            error_q <= error_d;
            light_q <= light_d;
        end
    end

    // Frame FSM; cs_rise takes priority over a coincident SCLK edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        count_d = count_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt_q == CNT_FULL) begin
                        freq_d  = shift_q[W-1:AMP_WIDTH];
                        amp_d   = shift_q[AMP_WIDTH-1:0];
                        valid_d = 1'b1;
                        count_d = count_q + 16'd1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sclk_edge_q) begin
                    shift_d = {shift_q[W-2:0], sdo_q};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        light_d = (state_d != IDLE);
    end

    assign spi.outputFrequencySample = freq_q;
    assign spi.outputAmplitudeSample = amp_q;
    assign spi.outputSampleValid     = valid_q;
    assign spi.outputFrameError      = error_q;
    assign spi.outputFrameCount      = count_q;
    assign spi.inputLight            = light_q;

endmodule
